// File: rtl/register_bank.sv
// register_bank: NREGS general registers with an auto-incrementing index
// register, plus an output queue with valid/ready and a last-output view.
module register_bank #(
  parameter int WIDTH = 8,
  parameter int NREGS = 3,
  parameter int XIDX  = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetB,
  input  logic [WIDTH-1:0]             dbus,
  input  logic [NREGS-1:0]             load,
  input  logic                         incX,
  input  logic                         doOut,
  input  logic                         clrOvf,
  output logic [NREGS*WIDTH-1:0]       regs,
  output logic [WIDTH-1:0]             qreg,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   out_count,
  output logic                         out_full,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r   [NREGS];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count_n;
  logic             pop;
  logic             push;
  logic             drop;

  assign pop  = out_valid & out_ready;
  assign push = doOut & (~out_full | pop);
  assign drop = doOut & out_full & ~pop;

  // Pack the register array onto the flat output bus
  always_comb begin
    regs = '0;
    for (int i = 0; i < NREGS; i++)
      regs[i*WIDTH +: WIDTH] = r[i];
  end

  // Head read is gated so an empty queue shows zero
  always_comb begin
    out_data = '0;
    if (out_valid)
      out_data = mem[head];
  end

  // Next occupancy from the accepted push and pop
  always_comb begin
    count_n = out_count;
    unique case ({push, pop})
      2'b10:   count_n = out_count + CW'(1);
      2'b01:   count_n = out_count - CW'(1);
      default: count_n = out_count;
    endcase
  end

  // General registers: load has priority over increment
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      for (int i = 0; i < NREGS; i++)
        r[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (load[i])
          r[i] <= dbus;
        else if (i == XIDX && incX)
          r[i] <= r[i] + WIDTH'(1);
      end
    end
  end

  // Queue storage, pointers, occupancy flags and last-output view
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      head      <= '0;
      tail      <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      out_full  <= 1'b0;
      qreg      <= '0;
    end else begin
      if (push) begin
        mem[tail] <= dbus;
        tail      <= tail + AW'(1);
        qreg      <= dbus;
      end
      if (pop)
        head <= head + AW'(1);
      out_count <= count_n;
      out_valid <= (count_n != '0);
      out_full  <= (count_n == CW'(DEPTH));
    end
  end

  // Sticky drop flag; a drop in the same cycle beats the clear
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clrOvf)
      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed vectors with hand-computed expectations
// for register_bank.
module tb_register_bank;

  logic        clk;
  logic        resetB;
  logic [7:0]  dbus;
  logic [2:0]  load;
  logic        incX;
  logic        doOut;
  logic        clrOvf;
  logic [23:0] regs;
  logic [7:0]  qreg;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_count;
  logic        out_full;
  logic        overflow;

  int npass;
  int ntot;

  register_bank dut (
    .clk(clk),
    .resetB(resetB),
    .dbus(dbus),
    .load(load),
    .incX(incX),
    .doOut(doOut),
    .clrOvf(clrOvf),
    .regs(regs),
    .qreg(qreg),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .out_full(out_full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp)
      npass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_regs"}, 32'(regs), 32'h0);
    chk({tag, "_qreg"}, 32'(qreg), 32'h0);
    chk({tag, "_data"}, 32'(out_data), 32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_count"}, 32'(out_count), 32'h0);
    chk({tag, "_full"}, 32'(out_full), 32'h0);
    chk({tag, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  logic [7:0] drain [4];

  initial begin
    npass = 0;
    ntot = 0;
    resetB = 1'b0;
    dbus = '0;
    load = '0;
    incX = 1'b0;
    doOut = 1'b0;
    clrOvf = 1'b0;
    out_ready = 1'b0;
    #3;
    chk_zero("rst");
    #9;
    resetB = 1'b1;
    tick();

    // Multi-load then single load
    load = 3'b011; dbus = 8'h5A;
    tick();
    load = 3'b100; dbus = 8'h07;
    tick();
    load = 3'b000;
    chk("ld_regs", 32'(regs), 32'h075A5A);
    chk("ld_valid", 32'(out_valid), 32'h0);
    chk("ld_qreg", 32'(qreg), 32'h0);

    // Increment wrap and load-over-increment
    load = 3'b100; dbus = 8'hFF;
    tick();
    load = 3'b000; incX = 1'b1;
    tick();
    chk("inc_wrap", 32'(regs[23:16]), 32'h00);
    load = 3'b100; dbus = 8'h40;
    tick();
    load = 3'b000;
    chk("inc_ldwin", 32'(regs[23:16]), 32'h40);
    tick();
    incX = 1'b0;
    chk("inc_41", 32'(regs[23:16]), 32'h41);
    chk("inc_ab", 32'(regs[15:0]), 32'h5A5A);

    // Fill, overflow, clear
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      doOut = 1'b1; dbus = 8'(v);
      tick();
    end
    doOut = 1'b0;
    chk("fill_full", 32'(out_full), 32'h1);
    chk("fill_cnt", 32'(out_count), 32'h4);
    chk("fill_qreg", 32'(qreg), 32'h04);
    chk("fill_head", 32'(out_data), 32'h01);
    chk("fill_ovf", 32'(overflow), 32'h0);
    doOut = 1'b1; dbus = 8'h05;
    tick();
    doOut = 1'b0;
    chk("drop_cnt", 32'(out_count), 32'h4);
    chk("drop_ovf", 32'(overflow), 32'h1);
    chk("drop_qreg", 32'(qreg), 32'h04);
    clrOvf = 1'b1;
    tick();
    clrOvf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'h0);

    // Push and pop at full
    doOut = 1'b1; dbus = 8'hAA; out_ready = 1'b1;
    tick();
    doOut = 1'b0;
    chk("pp_cnt", 32'(out_count), 32'h4);
    chk("pp_qreg", 32'(qreg), 32'hAA);
    chk("pp_ovf", 32'(overflow), 32'h0);
    drain[0] = 8'h02; drain[1] = 8'h03;
    drain[2] = 8'h04; drain[3] = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), 32'(out_data), 32'(drain[k]));
      tick();
    end
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_cnt", 32'(out_count), 32'h0);
    chk("drain_data", 32'(out_data), 32'h0);

    // Push and ready into an empty queue
    doOut = 1'b1; dbus = 8'h33; out_ready = 1'b1;
    #1;
    chk("emp_v0", 32'(out_valid), 32'h0);
    tick();
    doOut = 1'b0;
    chk("emp_v1", 32'(out_valid), 32'h1);
    chk("emp_data", 32'(out_data), 32'h33);
    chk("emp_cnt", 32'(out_count), 32'h1);
    tick();
    out_ready = 1'b0;
    chk("emp_v2", 32'(out_valid), 32'h0);

    // Reset mid-operation
    load = 3'b100; dbus = 8'h10;
    tick();
    load = 3'b000;
    doOut = 1'b1; dbus = 8'h11;
    tick();
    dbus = 8'h22;
    tick();
    doOut = 1'b0;
    chk("pre_cnt", 32'(out_count), 32'h2);
    chk("pre_x", 32'(regs[23:16]), 32'h10);
    #2;
    resetB = 1'b0;
    #1;
    chk_zero("mid");
    #3;
    resetB = 1'b1;
    doOut = 1'b1; dbus = 8'h99;
    tick();
    doOut = 1'b0;
    chk("post_data", 32'(out_data), 32'h99);
    chk("post_cnt", 32'(out_count), 32'h1);
    chk("post_valid", 32'(out_valid), 32'h1);
    chk("post_qreg", 32'(qreg), 32'h99);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
